// File: rtl/paddle_mover.sv
// Paddle position controller: turns debounced up/down press pulses into
// fixed-size steps played out at a bounded speed per video frame.
module paddle_mover #(
  parameter int SCREEN_H  = 480,
  parameter int PADDLE_H  = 80,
  parameter int STEP      = 16,
  parameter int SPEED     = 4,
  parameter int Y_INIT    = 200,
  parameter int QUEUE_MAX = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       up_pulse,
  input  logic       dn_pulse,
  input  logic       frame_tick,
  output logic [9:0] paddle_y,
  output logic       moving,
  output logic       at_top,
  output logic       at_bot
);

  // state     | meaning
  // S_IDLE    | no step in flight; launches the next queued press
  // S_MOVE_UP | playing out an up step (y decreasing) on frame ticks
  // S_MOVE_DN | playing out a down step (y increasing) on frame ticks
  typedef enum logic [1:0] {S_IDLE, S_MOVE_UP, S_MOVE_DN} state_t;

  localparam int PW = $clog2(QUEUE_MAX) + 2;
  localparam int RW = $clog2(STEP + 1);
  localparam logic [9:0] Y_MAX_V  = 10'(SCREEN_H - PADDLE_H);
  localparam logic [9:0] SPEED_V  = 10'(SPEED);
  localparam logic [9:0] Y_INIT_V = 10'(Y_INIT);
  localparam logic [RW-1:0] STEP_V = RW'(STEP);
  localparam logic signed [PW:0] P_ONE = (PW+1)'(1);
  localparam logic signed [PW:0] Q_MAX = (PW+1)'(QUEUE_MAX);
  localparam logic signed [PW:0] Q_MIN = -Q_MAX;
  localparam logic signed [PW:0] P_ZERO = '0;

  state_t                 state_q, state_d;
  logic [9:0]             y_q, y_d;
  logic [RW-1:0]          rem_q, rem_d;
  logic signed [PW-1:0]   pending_q, pending_d;
  logic                   moving_q, moving_d;

  logic signed [PW:0]     consumed;
  logic signed [PW:0]     sum;
  logic                   clr_pos, clr_neg;
  logic [9:0]             head, d, rem_ext;

  assign paddle_y = y_q;
  assign moving   = moving_q;
  assign at_top   = (y_q == 10'd0);
  assign at_bot   = (y_q == Y_MAX_V);

  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    rem_d    = rem_q;
    consumed = P_ZERO;
    clr_pos  = 1'b0;
    clr_neg  = 1'b0;
    head     = '0;
    d        = '0;
    rem_ext  = 10'(rem_q);

    case (state_q)
      S_IDLE: begin
        if (pending_q > 0) begin
          if (at_top) clr_pos = 1'b1;
          else begin
            state_d  = S_MOVE_UP;
            rem_d    = STEP_V;
            consumed = P_ONE;
          end
        end else if (pending_q < 0) begin
          if (at_bot) clr_neg = 1'b1;
          else begin
            state_d  = S_MOVE_DN;
            rem_d    = STEP_V;
            consumed = -P_ONE;
          end
        end
      end
      S_MOVE_UP, S_MOVE_DN: begin
        if (frame_tick) begin
          head = (state_q == S_MOVE_UP) ? y_q : (Y_MAX_V - y_q);
          d = SPEED_V;
          if (rem_ext < d) d = rem_ext;
          if (head < d)    d = head;
          rem_d = rem_q - RW'(d);
          if (state_q == S_MOVE_UP) begin
            y_d = y_q - d;
            clr_pos = (y_d == 10'd0);
          end else begin
            y_d = y_q + d;
            clr_neg = (y_d == Y_MAX_V);
          end
          // Hitting an edge ends the step even with pixels left over.
          if (rem_d == '0 || clr_pos || clr_neg) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    sum = {pending_q[PW-1], pending_q};
    if (up_pulse) sum = sum + P_ONE;
    if (dn_pulse) sum = sum - P_ONE;
    sum = sum - consumed;
    if (sum > Q_MAX) sum = Q_MAX;
    if (sum < Q_MIN) sum = Q_MIN;
    if (clr_pos && sum > 0) sum = P_ZERO;
    if (clr_neg && sum < 0) sum = P_ZERO;
    pending_d = sum[PW-1:0];

    moving_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      y_q       <= Y_INIT_V;
      rem_q     <= '0;
      pending_q <= '0;
      moving_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      rem_q     <= rem_d;
      pending_q <= pending_d;
      moving_q  <= moving_d;
    end
  end

endmodule

// File: tb/tb_paddle_mover.sv
// Directed bench for paddle_mover: default instance plus instances started
// near the top and bottom edges to exercise clamping.
module tb_paddle_mover;
  logic clk = 1'b0;
  logic rst_n, up_pulse, dn_pulse, frame_tick;
  logic [9:0] y, y8, yb;
  logic moving, at_top, at_bot;
  logic moving8, at_top8, at_bot8;
  logic movingb, at_topb, at_botb;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  paddle_mover dut (.clk(clk), .rst_n(rst_n), .up_pulse(up_pulse), .dn_pulse(dn_pulse),
    .frame_tick(frame_tick), .paddle_y(y), .moving(moving), .at_top(at_top), .at_bot(at_bot));
  paddle_mover #(.Y_INIT(8)) dut8 (.clk(clk), .rst_n(rst_n), .up_pulse(up_pulse),
    .dn_pulse(dn_pulse), .frame_tick(frame_tick), .paddle_y(y8), .moving(moving8),
    .at_top(at_top8), .at_bot(at_bot8));
  paddle_mover #(.Y_INIT(392)) dutb (.clk(clk), .rst_n(rst_n), .up_pulse(up_pulse),
    .dn_pulse(dn_pulse), .frame_tick(frame_tick), .paddle_y(yb), .moving(movingb),
    .at_top(at_topb), .at_bot(at_botb));

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; up_pulse = 1'b0; dn_pulse = 1'b0; frame_tick = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic press(input logic up);
    if (up) up_pulse = 1'b1; else dn_pulse = 1'b1;
    step();
    up_pulse = 1'b0; dn_pulse = 1'b0;
  endtask

  task automatic tick10();
    repeat (9) step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (y !== 10'd200) begin errors++; $display("FAIL reset_y got %0d exp 200", y); end
    checks++; if ({moving, at_top, at_bot} !== 3'b000) begin errors++;
      $display("FAIL reset_flags got %b exp 000", {moving, at_top, at_bot}); end
    checks++; if (dut.pending_q !== 4'sd0) begin errors++; $display("FAIL reset_pending got %0d exp 0", dut.pending_q); end
    checks++; if (y8 !== 10'd8 || yb !== 10'd392) begin errors++;
      $display("FAIL reset_init got %0d/%0d exp 8/392", y8, yb); end
  endtask

  task automatic test_single_up();
    logic [9:0] exp_y;
    do_reset();
    press(1'b1);
    checks++; if (dut.pending_q !== 4'sd1 || moving !== 1'b0) begin errors++;
      $display("FAIL single_pending got %0d mv %b exp 1 mv 0", dut.pending_q, moving); end
    step();
    checks++; if (moving !== 1'b1) begin errors++; $display("FAIL single_moving got %b exp 1", moving); end
    for (int i = 1; i <= 4; i++) begin
      tick10();
      exp_y = 10'(200 - 4 * i);
      checks++; if (y !== exp_y) begin errors++; $display("FAIL single_y%0d got %0d exp %0d", i, y, exp_y); end
      checks++; if (moving !== (i < 4)) begin errors++; $display("FAIL single_mv%0d got %b exp %b", i, moving, i < 4); end
    end
    repeat (3) tick10();
    checks++; if (y !== 10'd184 || moving !== 1'b0) begin errors++;
      $display("FAIL single_hold got %0d mv %b exp 184 mv 0", y, moving); end
  endtask

  task automatic test_queue_sat();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      press(1'b1);
      repeat (3) step();
    end
    checks++; if (dut.pending_q !== 4'sd3) begin errors++; $display("FAIL sat_pending got %0d exp 3", dut.pending_q); end
    checks++; if (y !== 10'd200 || moving !== 1'b1) begin errors++;
      $display("FAIL sat_notick got %0d mv %b exp 200 mv 1", y, moving); end
    repeat (16) tick10();
    checks++; if (y !== 10'd136 || moving !== 1'b0) begin errors++;
      $display("FAIL sat_final got %0d mv %b exp 136 mv 0", y, moving); end
    checks++; if (dut.pending_q !== 4'sd0) begin errors++; $display("FAIL sat_drain got %0d exp 0", dut.pending_q); end
  endtask

  task automatic test_top_clamp();
    do_reset();
    press(1'b1);
    repeat (3) step();
    press(1'b1);
    step();
    checks++; if (dut8.pending_q !== 4'sd1) begin errors++; $display("FAIL top_queued got %0d exp 1", dut8.pending_q); end
    tick10();
    checks++; if (y8 !== 10'd4 || moving8 !== 1'b1) begin errors++;
      $display("FAIL top_y1 got %0d mv %b exp 4 mv 1", y8, moving8); end
    tick10();
    checks++; if (y8 !== 10'd0 || moving8 !== 1'b0 || at_top8 !== 1'b1) begin errors++;
      $display("FAIL top_y2 got %0d mv %b top %b exp 0 mv 0 top 1", y8, moving8, at_top8); end
    checks++; if (dut8.pending_q !== 4'sd0) begin errors++; $display("FAIL top_clear got %0d exp 0", dut8.pending_q); end
    repeat (3) tick10();
    checks++; if (y8 !== 10'd0 || moving8 !== 1'b0) begin errors++;
      $display("FAIL top_hold got %0d mv %b exp 0 mv 0", y8, moving8); end
  endtask

  task automatic test_bot_clamp();
    do_reset();
    press(1'b0);
    repeat (3) step();
    press(1'b0);
    step();
    tick10();
    checks++; if (yb !== 10'd396) begin errors++; $display("FAIL bot_y1 got %0d exp 396", yb); end
    tick10();
    checks++; if (yb !== 10'd400 || at_botb !== 1'b1 || movingb !== 1'b0) begin errors++;
      $display("FAIL bot_y2 got %0d bot %b mv %b exp 400 1 0", yb, at_botb, movingb); end
    checks++; if (dutb.pending_q !== 4'sd0) begin errors++; $display("FAIL bot_clear got %0d exp 0", dutb.pending_q); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    up_pulse = 1'b1; dn_pulse = 1'b1;
    step();
    up_pulse = 1'b0; dn_pulse = 1'b0;
    checks++; if (dut.pending_q !== 4'sd0) begin errors++; $display("FAIL simul_pending got %0d exp 0", dut.pending_q); end
    tick10();
    checks++; if (y !== 10'd200 || moving !== 1'b0) begin errors++;
      $display("FAIL simul_y got %0d mv %b exp 200 mv 0", y, moving); end
  endtask

  task automatic test_opposite();
    logic [9:0] exp_seq [8] = '{10'd196, 10'd192, 10'd188, 10'd184, 10'd188, 10'd192, 10'd196, 10'd200};
    do_reset();
    press(1'b1);
    step();
    tick10();
    press(1'b0);
    checks++; if (dut.pending_q !== -4'sd1 || moving !== 1'b1) begin errors++;
      $display("FAIL opp_queued got %0d mv %b exp -1 mv 1", dut.pending_q, moving); end
    checks++; if (y !== exp_seq[0]) begin errors++; $display("FAIL opp_y0 got %0d exp %0d", y, exp_seq[0]); end
    for (int i = 1; i < 8; i++) begin
      tick10();
      checks++; if (y !== exp_seq[i]) begin errors++; $display("FAIL opp_y%0d got %0d exp %0d", i, y, exp_seq[i]); end
    end
    checks++; if (dut.pending_q !== 4'sd0 || moving !== 1'b0) begin errors++;
      $display("FAIL opp_final got %0d mv %b exp 0 mv 0", dut.pending_q, moving); end
  endtask

  task automatic test_async_reset();
    do_reset();
    press(1'b1);
    step();
    tick10();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (y !== 10'd200 || moving !== 1'b0 || dut.pending_q !== 4'sd0) begin errors++;
      $display("FAIL async_rst got %0d mv %b exp 200 mv 0", y, moving); end
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_single_up();
    test_queue_sat();
    test_top_clamp();
    test_bot_clamp();
    test_simultaneous();
    test_opposite();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
